// File: rtl/aes_controller_output.sv
// Output stage of the AES controller: buffers 128-bit result blocks (with a
// packet-last flag) in a first-word-fall-through FIFO and serialises each block
// onto a 32-bit AXI-stream-like bus, least significant word first.
module aes_controller_output #(
  parameter int unsigned BUS_DATA_WIDTH  = 32,
  parameter int unsigned FIFO_SIZE       = 16,
  parameter int unsigned FIFO_ADDR_WIDTH = 4,
  parameter int unsigned FIFO_DATA_WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       out_fifo_write_tvalid,
  output logic                       out_fifo_write_tready,
  input  logic [FIFO_DATA_WIDTH-1:0] out_fifo_wdata,
  input  logic                       out_fifo_wlast,
  output logic                       bus_tvalid,
  input  logic                       bus_tready,
  output logic [BUS_DATA_WIDTH-1:0]  bus_data,
  output logic                       bus_tlast,
  output logic                       out_fifo_empty,
  output logic                       controller_out_busy,
  output logic                       controller_out_done
);

  localparam int unsigned WORDS = FIFO_DATA_WIDTH / BUS_DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(WORDS);
  localparam logic [FIFO_ADDR_WIDTH:0]   FULL_CNT  = (FIFO_ADDR_WIDTH+1)'(FIFO_SIZE);
  localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ONE   = (FIFO_ADDR_WIDTH+1)'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE   = FIFO_ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]           WORD_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]           LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  // ---------------------------------------------------------------------------
  // Result FIFO: entry = {last, block}
  // ---------------------------------------------------------------------------
  logic [FIFO_DATA_WIDTH:0]   mem_q [FIFO_SIZE];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_WIDTH:0]   count_q;
  logic                       fifo_full;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_rd_valid;
  logic                       fifo_rd_ready;
  logic [FIFO_DATA_WIDTH:0]   fifo_rdata;

  assign fifo_full             = (count_q == FULL_CNT);
  assign fifo_rd_valid         = (count_q != '0);
  assign fifo_rdata            = mem_q[rd_ptr_q];
  assign fifo_push             = out_fifo_write_tvalid && !fifo_full;
  assign fifo_pop              = fifo_rd_valid && fifo_rd_ready;
  assign out_fifo_write_tready = !fifo_full;
  assign out_fifo_empty        = !fifo_rd_valid;

  // Storage array: written on every accepted push, never reset
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= {out_fifo_wlast, out_fifo_wdata};
    end
  end

  // Pointers and occupancy; clearing them on reset discards all stored blocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           word_cnt_q, word_cnt_d;
  logic [FIFO_DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                       last_q, last_d;
  logic                       done_q, done_d;

  // State, shift register, word counter and done pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  // Next-state: load a block at IDLE or on acceptance of the final word, so
  // consecutive blocks stream without a bubble
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    shreg_d       = shreg_q;
    last_d        = last_q;
    done_d        = 1'b0;
    fifo_rd_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fifo_rd_valid) begin
          fifo_rd_ready = 1'b1;
          shreg_d       = fifo_rdata[FIFO_DATA_WIDTH-1:0];
          last_d        = fifo_rdata[FIFO_DATA_WIDTH];
          word_cnt_d    = '0;
          state_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus_tready) begin
          shreg_d    = shreg_q >> BUS_DATA_WIDTH;
          word_cnt_d = word_cnt_q + WORD_ONE;
          if (word_cnt_q == LAST_WORD) begin
            done_d = last_q;
            if (fifo_rd_valid) begin
              fifo_rd_ready = 1'b1;
              shreg_d       = fifo_rdata[FIFO_DATA_WIDTH-1:0];
              last_d        = fifo_rdata[FIFO_DATA_WIDTH];
              word_cnt_d    = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_tvalid          = (state_q == ST_SEND);
  assign bus_data            = shreg_q[BUS_DATA_WIDTH-1:0];
  assign bus_tlast           = (state_q == ST_SEND) && last_q && (word_cnt_q == LAST_WORD);
  assign controller_out_busy = (state_q == ST_SEND) || fifo_rd_valid;
  assign controller_out_done = done_q;

endmodule

// File: tb/tb_aes_controller_output.sv
// Self-checking bench for aes_controller_output: a queue of expected bus words
// is built from every accepted FIFO write and consumed on every bus handshake.
module tb_aes_controller_output;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         out_fifo_write_tvalid;
  logic         out_fifo_write_tready;
  logic [127:0] out_fifo_wdata;
  logic         out_fifo_wlast;
  logic         bus_tvalid;
  logic         bus_tready;
  logic [31:0]  bus_data;
  logic         bus_tlast;
  logic         out_fifo_empty;
  logic         controller_out_busy;
  logic         controller_out_done;

  always #5 clk = ~clk;

  aes_controller_output #(
    .BUS_DATA_WIDTH (32),
    .FIFO_SIZE      (16),
    .FIFO_ADDR_WIDTH(4),
    .FIFO_DATA_WIDTH(128)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .out_fifo_write_tvalid(out_fifo_write_tvalid),
    .out_fifo_write_tready(out_fifo_write_tready),
    .out_fifo_wdata       (out_fifo_wdata),
    .out_fifo_wlast       (out_fifo_wlast),
    .bus_tvalid           (bus_tvalid),
    .bus_tready           (bus_tready),
    .bus_data             (bus_data),
    .bus_tlast            (bus_tlast),
    .out_fifo_empty       (out_fifo_empty),
    .controller_out_busy  (controller_out_busy),
    .controller_out_done  (controller_out_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: expected word stream
  logic [31:0] exp_data_q[$];
  logic        exp_last_q[$];
  int          words_seen, first_hs, last_hs, done_seen;
  bit          pend_done, prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;

  // Monitor: sampled on the falling edge, inputs are stable across the next rising edge
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      exp_data_q.delete();
      exp_last_q.delete();
      pend_done  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (controller_out_done !== pend_done) begin
        errors++;
        $display("FAIL done_pulse cyc=%0d got %b exp %b", cyc, controller_out_done, pend_done);
      end
      if (controller_out_done === 1'b1) done_seen++;
      if (prev_stall) begin
        checks++;
        if (bus_tvalid !== 1'b1 || bus_data !== prev_data || bus_tlast !== prev_last) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   cyc, bus_tvalid, bus_data, bus_tlast, prev_data, prev_last);
        end
      end
      if (out_fifo_write_tvalid && out_fifo_write_tready) begin
        for (int k = 0; k < 4; k++) begin
          exp_data_q.push_back(out_fifo_wdata[k*32 +: 32]);
          exp_last_q.push_back(out_fifo_wlast && (k == 3));
        end
      end
      pend_done = 1'b0;
      if (bus_tvalid === 1'b1 && bus_tready === 1'b1) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word cyc=%0d got %h exp none", cyc, bus_data);
        end else begin
          logic [31:0] ed;
          logic        el;
          ed = exp_data_q.pop_front();
          el = exp_last_q.pop_front();
          if (bus_data !== ed || bus_tlast !== el) begin
            errors++;
            $display("FAIL word cyc=%0d got %h/%b exp %h/%b", cyc, bus_data, bus_tlast, ed, el);
          end
        end
        words_seen++;
        if (first_hs < 0) first_hs = cyc;
        last_hs   = cyc;
        pend_done = (bus_tlast === 1'b1);
      end
      prev_stall = (bus_tvalid === 1'b1) && (bus_tready !== 1'b1);
      prev_data  = bus_data;
      prev_last  = bus_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    words_seen = 0;
    first_hs   = -1;
    last_hs    = -1;
    done_seen  = 0;
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present one block and hold it until the FIFO accepts it
  task automatic push(input logic [127:0] d, input logic l);
    int n;
    out_fifo_write_tvalid = 1'b1;
    out_fifo_wdata        = d;
    out_fifo_wlast        = l;
    n = 0;
    @(negedge clk);
    while (out_fifo_write_tready !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) begin
      errors++;
      $display("FAIL push_timeout got tready=%b exp 1", out_fifo_write_tready);
    end
    tick();
    out_fifo_write_tvalid = 1'b0;
  endtask

  // Drive bus_tready (0: always 1, 1: pattern 1,0,0, 2: random) until drained
  task automatic drain(input int mode, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      case (mode)
        0:       bus_tready = 1'b1;
        1:       bus_tready = ((i % 3) == 0);
        default: bus_tready = 1'($urandom_range(0, 1));
      endcase
      tick();
      if (exp_data_q.size() == 0 && controller_out_busy === 1'b0) break;
    end
    checks++;
    if (i >= max_cyc) begin
      errors++;
      $display("FAIL drain_timeout got %0d words left exp 0", exp_data_q.size());
    end
    bus_tready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    out_fifo_write_tvalid = 1'b0;
    out_fifo_wdata = '0;
    out_fifo_wlast = 1'b0;
    bus_tready = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({bus_tvalid, bus_tlast, bus_data, controller_out_done} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b l=%b d=%h done=%b exp all 0",
               bus_tvalid, bus_tlast, bus_data, controller_out_done);
    end
    checks++;
    if ({out_fifo_empty, controller_out_busy, out_fifo_write_tready} !== 3'b101) begin
      errors++;
      $display("FAIL reset_status got empty/busy/tready=%b%b%b exp 101",
               out_fifo_empty, controller_out_busy, out_fifo_write_tready);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    clear_stats();
    bus_tready = 1'b1;
    push(128'h33333333_22222222_11111111_00000000, 1'b1);
    drain(0, 100);
    checks++;
    if (words_seen != 4 || last_hs - first_hs != 3) begin
      errors++;
      $display("FAIL single_words got n=%0d span=%0d exp n=4 span=3", words_seen, last_hs - first_hs);
    end
    checks++;
    if (done_seen != 1) begin
      errors++;
      $display("FAIL single_done got %0d exp 1", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    bus_tready = 1'b1;
    for (int b = 0; b < 3; b++) push(rand_block(), b == 2);
    drain(0, 200);
    checks++;
    if (words_seen != 12 || last_hs - first_hs != 11) begin
      errors++;
      $display("FAIL b2b_words got n=%0d span=%0d exp n=12 span=11", words_seen, last_hs - first_hs);
    end
    checks++;
    if (done_seen != 1) begin
      errors++;
      $display("FAIL b2b_done got %0d exp 1", done_seen);
    end
  endtask

  task automatic test_stall();
    int nlast;
    clear_stats();
    bus_tready = 1'b0;
    push(rand_block(), 1'b0);
    push(rand_block(), 1'b1);
    drain(1, 200);
    nlast = 0;
    for (int b = 0; b < 5; b++) begin
      logic l;
      l = 1'($urandom_range(0, 1));
      nlast += int'(l);
      bus_tready = 1'($urandom_range(0, 1));
      push(rand_block(), l);
    end
    drain(2, 500);
    checks++;
    if (words_seen != 28 || done_seen != 1 + nlast) begin
      errors++;
      $display("FAIL stall_count got n=%0d done=%0d exp n=28 done=%0d", words_seen, done_seen, 1 + nlast);
    end
  endtask

  task automatic test_fill();
    clear_stats();
    bus_tready = 1'b0;
    for (int b = 0; b < 17; b++) push(rand_block(), 1'($urandom_range(0, 1)));
    tick();
    checks++;
    if (out_fifo_write_tready !== 1'b0 || out_fifo_empty !== 1'b0 || controller_out_busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_full got tready/empty/busy=%b%b%b exp 001",
               out_fifo_write_tready, out_fifo_empty, controller_out_busy);
    end
    drain(0, 500);
    checks++;
    if (words_seen != 68 || out_fifo_empty !== 1'b1 || controller_out_busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_drain got n=%0d empty=%b busy=%b exp n=68 empty=1 busy=0",
               words_seen, out_fifo_empty, controller_out_busy);
    end
  endtask

  task automatic test_push_pop_full();
    clear_stats();
    bus_tready = 1'b0;
    for (int b = 0; b < 16; b++) push(rand_block(), 1'b0);
    checks++;
    if (out_fifo_write_tready !== 1'b1) begin
      errors++;
      $display("FAIL pp_pre got tready=%b exp 1", out_fifo_write_tready);
    end
    bus_tready = 1'b1;
    tick(); tick(); tick();
    out_fifo_write_tvalid = 1'b1;
    out_fifo_wdata        = rand_block();
    out_fifo_wlast        = 1'b0;
    @(negedge clk);
    checks++;
    if (out_fifo_write_tready !== 1'b1 || bus_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL pp_same_cycle got tready=%b tvalid=%b exp 1 1", out_fifo_write_tready, bus_tvalid);
    end
    tick();
    out_fifo_write_tvalid = 1'b0;
    bus_tready = 1'b0;
    checks++;
    if (out_fifo_write_tready !== 1'b1) begin
      errors++;
      $display("FAIL pp_after got tready=%b exp 1", out_fifo_write_tready);
    end
    push(rand_block(), 1'b1);
    checks++;
    if (out_fifo_write_tready !== 1'b0) begin
      errors++;
      $display("FAIL pp_full got tready=%b exp 0", out_fifo_write_tready);
    end
    drain(0, 500);
    checks++;
    if (words_seen != 72) begin
      errors++;
      $display("FAIL pp_words got %0d exp 72", words_seen);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int dn;
    clear_stats();
    bus_tready = 1'b1;
    push(rand_block(), 1'b1);
    push(rand_block(), 1'b1);
    n = 0;
    while (words_seen < 2 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (words_seen != 2) begin
      errors++;
      $display("FAIL rst_mid_setup got %0d words exp 2", words_seen);
    end
    dn = done_seen;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus_tvalid !== 1'b0 || bus_tlast !== 1'b0 || out_fifo_empty !== 1'b1 || controller_out_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async got v=%b l=%b empty=%b busy=%b exp 0 0 1 0",
               bus_tvalid, bus_tlast, out_fifo_empty, controller_out_busy);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (done_seen != dn) begin
      errors++;
      $display("FAIL rst_mid_done got %0d exp %0d", done_seen, dn);
    end
    clear_stats();
    push(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1);
    drain(0, 100);
    checks++;
    if (words_seen != 4 || done_seen != 1) begin
      errors++;
      $display("FAIL rst_mid_restart got n=%0d done=%0d exp n=4 done=1", words_seen, done_seen);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    pend_done  = 1'b0;
    prev_stall = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_fill();
    test_push_pop_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
